segment_feeder: RTL

SEGMENT_FEEDER -- requirements
Module: segment_feeder

---
 rtl/segment_feeder_pkg.sv | 35 +++
 rtl/segment_fifo.sv | 75 +++++++
 rtl/segment_feeder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_feeder_pkg.sv
// Shared definitions for the segment feeder: segment word layout and FSM state encoding.
package segment_feeder_pkg;

    localparam int STEPS_W = 32;
    localparam int PARAM_W = 64;
    localparam int WORD_W  = 32;
    localparam int SEG_W   = 96;

    // Segment word is {steps, param}
    localparam int SEG_PARAM_LSB = 0;
    localparam int SEG_STEPS_LSB = PARAM_W;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_PRIME_LO  = 4'd1;
    localparam state_t ST_PRIME_HI  = 4'd2;
    localparam state_t ST_START     = 4'd3;
    localparam state_t ST_RUN       = 4'd4;
    localparam state_t ST_LOAD_LO   = 4'd5;
    localparam state_t ST_LOAD_HI   = 4'd6;
    localparam state_t ST_LOAD_DONE = 4'd7;
    localparam state_t ST_UNDERRUN  = 4'd8;
    localparam state_t ST_FLUSH     = 4'd9;

    function automatic logic [SEG_W-1:0] pack_segment(input logic [STEPS_W-1:0] steps,
                                                      input logic [PARAM_W-1:0] param);
        logic [SEG_W-1:0] seg;
        seg = '0;
        seg[SEG_STEPS_LSB +: STEPS_W] = steps;
        seg[SEG_PARAM_LSB +: PARAM_W] = param;
        return seg;
    endfunction

endpackage

// File: rtl/segment_fifo.sv
// Segment FIFO: power-of-two depth, registered count, synchronous flush.
module segment_fifo
    import segment_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = SEG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/segment_feeder.sv
// Feeds queued motion segments to a step generator. Optional statistics (err_underrun,
// seg_done_count) are enabled by defining SEGMENT_FEEDER_STATS_EN.
module segment_feeder
    import segment_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seg_push,
    input  logic [STEPS_W-1:0]     seg_steps,
    input  logic [PARAM_W-1:0]     seg_param,
    input  logic                   seg_last,
    input  logic                   run,
    input  logic [31:0]            run_dt,
    input  logic                   abort_req,
    output logic                   start,
    output logic                   abort,
    output logic                   param_write_lo,
    output logic                   param_write_hi,
    output logic [WORD_W-1:0]      param_data,
    output logic                   params_load_done,
    output logic [31:0]            dt_val,
    output logic [STEPS_W-1:0]     steps_val,
    input  logic                   load_next_params,
    input  logic                   waiting_for_params,
    input  logic                   busy,
    input  logic                   done,
    input  logic                   global_abort,
    output logic                   seg_full,
    output logic [$clog2(DEPTH):0] seg_count,
    output logic                   running,
    output logic                   err_overflow,
    output logic                   err_underrun,
    output logic [15:0]            seg_done_count
);

    state_t               state_q, state_d;
    logic                 start_q, start_d;
    logic                 abort_q, abort_d;
    logic                 lo_q, lo_d;
    logic                 hi_q, hi_d;
    logic                 pld_q, pld_d;
    logic [WORD_W-1:0]    param_data_q, param_data_d;
    logic [31:0]          dt_val_q, dt_val_d;
    logic [31:0]          dt_hold_q, dt_hold_d;
    logic [STEPS_W-1:0]   steps_val_q, steps_val_d;
    logic                 running_q, running_d;
    logic                 end_q, end_d;
    logic                 err_overflow_q, err_overflow_d;

    logic                 fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [SEG_W-1:0]     fifo_rdata;
    logic [STEPS_W-1:0]   head_steps;
    logic [PARAM_W-1:0]   head_param;

    assign fifo_push  = seg_push & (state_q != ST_FLUSH);
    assign head_steps = fifo_rdata[SEG_STEPS_LSB +: STEPS_W];
    assign head_param = fifo_rdata[SEG_PARAM_LSB +: PARAM_W];

    segment_fifo #(.DEPTH(DEPTH), .W(SEG_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (pack_segment(seg_steps, seg_param)),
        .rdata (fifo_rdata),
        .count (seg_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        start_d        = 1'b0;
        abort_d        = 1'b0;
        lo_d           = 1'b0;
        hi_d           = 1'b0;
        pld_d          = 1'b0;
        param_data_d   = param_data_q;
        dt_val_d       = dt_val_q;
        dt_hold_d      = dt_hold_q;
        steps_val_d    = steps_val_q;
        running_d      = running_q;
        end_d          = end_q | (seg_last & (state_q != ST_FLUSH));
        err_overflow_d = err_overflow_q | (fifo_push & fifo_full);
        fifo_pop       = 1'b0;
        fifo_flush     = (state_q == ST_FLUSH);

        // An external abort silently takes over; a host abort is echoed to the step generator.
        if (global_abort && state_q != ST_IDLE && state_q != ST_FLUSH) begin
            state_d = ST_FLUSH;
        end else if (abort_req && state_q != ST_IDLE) begin
            abort_d = 1'b1;
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run && !fifo_empty && !busy && waiting_for_params) begin
                        state_d      = ST_PRIME_LO;
                        lo_d         = 1'b1;
                        param_data_d = head_param[WORD_W-1:0];
                        dt_hold_d    = run_dt;
                    end
                end
                ST_PRIME_LO: begin
                    state_d      = ST_PRIME_HI;
                    hi_d         = 1'b1;
                    param_data_d = head_param[PARAM_W-1:WORD_W];
                end
                ST_PRIME_HI: begin
                    state_d     = ST_START;
                    start_d     = 1'b1;
                    dt_val_d    = dt_hold_q;
                    steps_val_d = head_steps;
                    fifo_pop    = 1'b1;
                    running_d   = 1'b1;
                end
                ST_START: state_d = ST_RUN;
                ST_RUN: begin
                    if (load_next_params) begin
                        if (!fifo_empty) begin
                            state_d      = ST_LOAD_LO;
                            lo_d         = 1'b1;
                            param_data_d = head_param[WORD_W-1:0];
                        end else if (end_q || seg_last) begin
                            state_d     = ST_LOAD_DONE;
                            pld_d       = 1'b1;
                            steps_val_d = '0;
                        end else begin
                            state_d = ST_UNDERRUN;
                        end
                    end
                end
                ST_UNDERRUN: begin
                    // A segment pushed this cycle is not yet at the FIFO head, so bypass it.
                    if (!fifo_empty || seg_push) begin
                        state_d      = ST_LOAD_LO;
                        lo_d         = 1'b1;
                        param_data_d = fifo_empty ? seg_param[WORD_W-1:0] : head_param[WORD_W-1:0];
                    end else if (end_q || seg_last) begin
                        state_d     = ST_LOAD_DONE;
                        pld_d       = 1'b1;
                        steps_val_d = '0;
                    end
                end
                ST_LOAD_LO: begin
                    state_d      = ST_LOAD_HI;
                    hi_d         = 1'b1;
                    param_data_d = head_param[PARAM_W-1:WORD_W];
                end
                ST_LOAD_HI: begin
                    state_d     = ST_LOAD_DONE;
                    pld_d       = 1'b1;
                    steps_val_d = head_steps;
                    fifo_pop    = 1'b1;
                end
                ST_LOAD_DONE: begin
                    if (steps_val_q != '0) begin
                        state_d = ST_RUN;
                    end else if (done) begin
                        state_d = ST_IDLE;
                        end_d   = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    end_d = 1'b0;
                    if (!busy) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d == ST_IDLE) running_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            start_q        <= 1'b0;
            abort_q        <= 1'b0;
            lo_q           <= 1'b0;
            hi_q           <= 1'b0;
            pld_q          <= 1'b0;
            param_data_q   <= '0;
            dt_val_q       <= '0;
            dt_hold_q      <= '0;
            steps_val_q    <= '0;
            running_q      <= 1'b0;
            end_q          <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            abort_q        <= abort_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            pld_q          <= pld_d;
            param_data_q   <= param_data_d;
            dt_val_q       <= dt_val_d;
            dt_hold_q      <= dt_hold_d;
            steps_val_q    <= steps_val_d;
            running_q      <= running_d;
            end_q          <= end_d;
            err_overflow_q <= err_overflow_d;
        end
    end

`ifdef SEGMENT_FEEDER_STATS_EN
    logic        err_underrun_q, err_underrun_d;
    logic [15:0] seg_done_count_q, seg_done_count_d;

    always_comb begin
        err_underrun_d   = err_underrun_q | (state_d == ST_UNDERRUN);
        seg_done_count_d = seg_done_count_q + (fifo_pop ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underrun_q   <= 1'b0;
            seg_done_count_q <= '0;
        end else begin
            err_underrun_q   <= err_underrun_d;
            seg_done_count_q <= seg_done_count_d;
        end
    end

    assign err_underrun   = err_underrun_q;
    assign seg_done_count = seg_done_count_q;
`else
    assign err_underrun   = 1'b0;
    assign seg_done_count = '0;
`endif

    assign start            = start_q;
    assign abort            = abort_q;
    assign param_write_lo   = lo_q;
    assign param_write_hi   = hi_q;
    assign param_data       = param_data_q;
    assign params_load_done = pld_q;
    assign dt_val           = dt_val_q;
    assign steps_val        = steps_val_q;
    assign running          = running_q;
    assign err_overflow     = err_overflow_q;
    assign seg_full         = fifo_full;

endmodule
